// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the requesters, the round-robin arbiter and the single-port RAM slave.
// master = arbiter side; slave = requesters plus RAM side.
interface mem_bus_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    req_rw;
  logic [NUM_REQ*16-1:0] req_addr;
  logic [NUM_REQ*32-1:0] req_wdata;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    done;
  logic [31:0]           rdata;
  logic                  err;
  logic                  mem_cs;
  logic                  mem_rw;
  logic [15:0]           mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_ready;
  logic [31:0]           mem_rdata;

  modport master (
    input  req, req_rw, req_addr, req_wdata, mem_ready, mem_rdata,
    output gnt, done, rdata, err, mem_cs, mem_rw, mem_addr, mem_wdata
  );

  modport slave (
    output req, req_rw, req_addr, req_wdata, mem_ready, mem_rdata,
    input  gnt, done, rdata, err, mem_cs, mem_rw, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one single-port 32-bit RAM slave among NUM_REQ requesters.
// Optional ready timeout with abort flag enabled by defining MEM_BUS_ARBITER_TIMEOUT_EN.
module mem_bus_arbiter #(
  parameter int NUM_REQ = 4
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 15
`endif
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_arbiter_if.master bus
);
  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RELEASE = 2'd2} state_t;

  state_t               r_state, w_state_nxt;
  logic [PW-1:0]        r_ptr, w_ptr_nxt;
  logic [PW-1:0]        r_win, w_win_nxt;
  logic [PW-1:0]        w_pick, w_idx;
  logic                 w_found;
  logic [NUM_REQ-1:0]   r_gnt, w_gnt_nxt;
  logic [NUM_REQ-1:0]   r_done, w_done_nxt;
  logic [31:0]          r_rdata, w_rdata_nxt;
  logic                 r_cs, w_cs_nxt;
  logic                 r_rw, w_rw_nxt;
  logic [15:0]          r_addr, w_addr_nxt;
  logic [31:0]          r_wdata, w_wdata_nxt;
  logic                 w_timeout;
  logic [15:0]          w_addr_a  [NUM_REQ];
  logic [31:0]          w_wdata_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addr_a[g]  = bus.req_addr[16*g +: 16];
    assign w_wdata_a[g] = bus.req_wdata[32*g +: 32];
  end

  // First requesting bit at or above the pointer, wrapping modulo NUM_REQ
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_idx   = r_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = PW'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] r_cnt;
  logic          r_err;

  // Counter sits at zero outside ACCESS, so it starts cleared on every grant
  assign w_timeout = (r_state == ACCESS) && (r_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= (r_state == ACCESS) ? r_cnt + CW'(1) : '0;
      if (w_timeout && !bus.mem_ready) r_err <= 1'b1;
      else if (r_state == RELEASE)     r_err <= 1'b0;
    end
  end

  assign bus.err = r_err;
`else
  assign w_timeout = 1'b0;
  assign bus.err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_win   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_rdata <= '0;
      r_cs    <= 1'b0;
      r_rw    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_win   <= w_win_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_rdata <= w_rdata_nxt;
      r_cs    <= w_cs_nxt;
      r_rw    <= w_rw_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_found) w_state_nxt = ACCESS;
      ACCESS:  if (bus.mem_ready || w_timeout) w_state_nxt = RELEASE;
      RELEASE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_ptr_nxt   = r_ptr;
    w_win_nxt   = r_win;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = r_done;
    w_rdata_nxt = r_rdata;
    w_cs_nxt    = r_cs;
    w_rw_nxt    = r_rw;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_win_nxt   = w_pick;
          w_gnt_nxt   = NUM_REQ'(1) << w_pick;
          w_cs_nxt    = 1'b1;
          w_rw_nxt    = bus.req_rw[w_pick];
          w_addr_nxt  = w_addr_a[w_pick];
          w_wdata_nxt = w_wdata_a[w_pick];
        end
      end
      ACCESS: begin
        // A ready arriving on the timeout cycle still completes normally
        if (bus.mem_ready) begin
          w_done_nxt  = r_gnt;
          w_cs_nxt    = 1'b0;
          w_rdata_nxt = r_rw ? bus.mem_rdata : 32'h0;
        end else if (w_timeout) begin
          w_done_nxt  = r_gnt;
          w_cs_nxt    = 1'b0;
          w_rdata_nxt = 32'hDEAD_BEEF;
        end
      end
      RELEASE: begin
        w_ptr_nxt   = (r_win == PW'(NUM_REQ - 1)) ? '0 : r_win + PW'(1);
        w_gnt_nxt   = '0;
        w_done_nxt  = '0;
        w_rdata_nxt = '0;
        w_cs_nxt    = 1'b0;
        w_rw_nxt    = 1'b0;
        w_addr_nxt  = '0;
        w_wdata_nxt = '0;
      end
      default: ;
    endcase
  end

  assign bus.gnt       = r_gnt;
  assign bus.done      = r_done;
  assign bus.rdata     = r_rdata;
  assign bus.mem_cs    = r_cs;
  assign bus.mem_rw    = r_rw;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter with a behavioural RAM slave and round-robin model.
// Covers reset, reads/writes, contention, withdrawal, mid-transaction reset, stalls and random traffic.
module tb_mem_bus_arbiter;
  localparam int N  = 4;
  localparam int TO = 15;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   m_ptr  = 0;
  logic [31:0] m_mem [int];
  bit   stall = 1'b0;
  bit   poke  = 1'b0;

  logic [31:0] ram [0:255];
  int          sl_st;
  logic        sl_ready;
  logic [31:0] sl_rdata;

  mem_bus_arbiter_if #(.NUM_REQ(N)) bus ();
  mem_bus_arbiter #(.NUM_REQ(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(int w);
    return (w == 16) ? 32'h1234_5678 : (32'hA5A5_0000 ^ (32'(w) * 32'h0001_0203));
  endfunction

  function automatic int rr_pick(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [31:0] m_read(logic [15:0] a);
    int w;
    w = int'(a[9:2]);
    return m_mem.exists(w) ? m_mem[w] : pat(w);
  endfunction

  // RAM slave: RUN one cycle after cs, ready pulse one cycle later, idle once cs drops
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sl_st    <= 0;
      sl_ready <= 1'b0;
      sl_rdata <= 32'h0;
      for (int i = 0; i < 256; i++) ram[i] <= pat(i);
    end else begin
      case (sl_st)
        0: if (bus.mem_cs) sl_st <= 1;
        1: begin
          if (!bus.mem_cs) sl_st <= 0;
          else if (!stall) begin
            if (bus.mem_rw) sl_rdata <= ram[bus.mem_addr[9:2]];
            else            ram[bus.mem_addr[9:2]] <= bus.mem_wdata;
            sl_ready <= 1'b1;
            sl_st    <= 2;
          end
        end
        2: begin
          sl_ready <= 1'b0;
          sl_st    <= 3;
        end
        default: if (!bus.mem_cs) sl_st <= 0;
      endcase
    end
  end

  assign bus.mem_ready = sl_ready | poke;
  assign bus.mem_rdata = sl_rdata;

  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if (!$onehot0(bus.gnt) || !$onehot0(bus.done) || (bus.done != '0 && bus.done != bus.gnt)) begin
        errors++;
        $display("FAIL onehot_monitor: gnt=%b done=%b, required one-hot gnt and done equal to gnt", bus.gnt, bus.done);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic set_req(int i, logic rw, logic [15:0] a, logic [31:0] d);
    bus.req_rw[i]             = rw;
    bus.req_addr[16*i +: 16]  = a;
    bus.req_wdata[32*i +: 32] = d;
  endtask

  task automatic randomize_inputs(logic [N-1:0] r);
    for (int i = 0; i < N; i++) set_req(i, 1'($urandom), 16'($urandom), $urandom);
    bus.req = r;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_ptr = 0;
    m_mem.delete();
  endtask

  task automatic wait_gnt(input int bound, output int c);
    c = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (bus.gnt != '0) begin
        c = i;
        return;
      end
    end
  endtask

  task automatic wait_done(input int bound, output int c);
    c = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (bus.done != '0) begin
        c = i;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    randomize_inputs('1);
    repeat (3) @(negedge clk);
    checks++; if (bus.gnt !== '0)   begin errors++; $display("FAIL reset_gnt: got %b need 0", bus.gnt); end
    checks++; if (bus.done !== '0)  begin errors++; $display("FAIL reset_done: got %b need 0", bus.done); end
    checks++; if (bus.rdata !== 0)  begin errors++; $display("FAIL reset_rdata: got %h need 0", bus.rdata); end
    checks++; if (bus.err !== 0)    begin errors++; $display("FAIL reset_err: got %b need 0", bus.err); end
    checks++; if (bus.mem_cs !== 0) begin errors++; $display("FAIL reset_cs: got %b need 0", bus.mem_cs); end
    checks++; if (bus.mem_rw !== 0) begin errors++; $display("FAIL reset_rw: got %b need 0", bus.mem_rw); end
    checks++; if (bus.mem_addr !== 0)  begin errors++; $display("FAIL reset_addr: got %h need 0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 0) begin errors++; $display("FAIL reset_wdata: got %h need 0", bus.mem_wdata); end
    bus.req = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.gnt !== '0 || bus.mem_cs !== 0) begin
      errors++; $display("FAIL idle_no_req: gnt=%b cs=%b need 0/0", bus.gnt, bus.mem_cs);
    end
  endtask

  task automatic test_single_read();
    int c, ncs;
    do_reset();
    set_req(2, 1'b1, 16'h0040, 32'h0BAD_0BAD);
    bus.req = 4'b0100;
    wait_gnt(8, c);
    checks++; if (c != 1 || bus.gnt !== 4'b0100) begin errors++; $display("FAIL sr_gnt: got %b after %0d need 0100 after 1", bus.gnt, c); end
    ncs = bus.mem_cs ? 1 : 0;
    c = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.done != '0) begin c = i; break; end
      if (bus.mem_cs) ncs++;
    end
    bus.req = '0;
    checks++; if (c != 3)  begin errors++; $display("FAIL sr_latency: got %0d need 3", c); end
    checks++; if (ncs != 3) begin errors++; $display("FAIL sr_cs_cycles: got %0d need 3", ncs); end
    checks++; if (bus.done !== 4'b0100) begin errors++; $display("FAIL sr_done: got %b need 0100", bus.done); end
    checks++; if (bus.rdata !== 32'h1234_5678) begin errors++; $display("FAIL sr_rdata: got %h need 12345678", bus.rdata); end
    checks++; if (bus.err !== 0 || bus.mem_cs !== 0) begin errors++; $display("FAIL sr_err_cs: err=%b cs=%b need 0/0", bus.err, bus.mem_cs); end
    @(negedge clk);
    checks++; if (bus.done !== '0 || bus.gnt !== '0 || bus.rdata !== 0) begin
      errors++; $display("FAIL sr_release: done=%b gnt=%b rdata=%h need all 0", bus.done, bus.gnt, bus.rdata);
    end
  endtask

  task automatic test_write_readback();
    int c;
    time t0;
    do_reset();
    set_req(1, 1'b0, 16'h0100, 32'hCAFE_F00D);
    bus.req = 4'b0010;
    wait_gnt(8, c);
    t0 = $time;
    checks++; if (bus.gnt !== 4'b0010 || bus.mem_rw !== 0 || bus.mem_wdata !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL wr_gnt: gnt=%b rw=%b wdata=%h need 0010/0/cafef00d", bus.gnt, bus.mem_rw, bus.mem_wdata);
    end
    wait_done(8, c);
    checks++; if (bus.done !== 4'b0010 || bus.rdata !== 0) begin
      errors++; $display("FAIL wr_done: done=%b rdata=%h need 0010/0", bus.done, bus.rdata);
    end
    bus.req_rw[1] = 1'b1;
    wait_gnt(8, c);
    checks++; if (bus.gnt !== 4'b0010 || (($time - t0) / 10) != 5) begin
      errors++; $display("FAIL rb_gnt: gnt=%b spacing=%0d need 0010 spacing 5", bus.gnt, ($time - t0) / 10);
    end
    wait_done(8, c);
    bus.req = '0;
    checks++; if (bus.done !== 4'b0010 || bus.rdata !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL rb_rdata: done=%b rdata=%h need 0010/cafef00d", bus.done, bus.rdata);
    end
  endtask

  task automatic test_contention();
    int c, w;
    time tg;
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 16'($urandom), $urandom);
    bus.req = '1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_ptr = 0;
    m_mem.delete();
    tg = 0;
    for (int k = 0; k < 5; k++) begin
      w = rr_pick('1, m_ptr);
      wait_gnt(8, c);
      checks++; if (bus.gnt !== N'(1) << w) begin errors++; $display("FAIL cont_gnt%0d: got %b need %b", k, bus.gnt, N'(1) << w); end
      if (k > 0) begin
        checks++; if ((($time - tg) / 10) != 5) begin errors++; $display("FAIL cont_spacing%0d: got %0d need 5", k, ($time - tg) / 10); end
      end
      tg = $time;
      wait_done(8, c);
      checks++; if (c != 3 || bus.done !== N'(1) << w || bus.rdata !== m_read(bus.req_addr[16*w +: 16])) begin
        errors++; $display("FAIL cont_done%0d: done=%b rdata=%h lat=%0d need %b/%h/3", k, bus.done, bus.rdata, c,
                           N'(1) << w, m_read(bus.req_addr[16*w +: 16]));
      end
      m_ptr = (w + 1) % N;
    end
    bus.req = '0;
  endtask

  task automatic test_withdrawal();
    int c;
    do_reset();
    set_req(1, 1'b1, 16'h0010, 32'h0);
    set_req(3, 1'b1, 16'h0020, 32'h0);
    bus.req = 4'b1010;
    wait_gnt(8, c);
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL wd_first: got %b need 0010", bus.gnt); end
    wait_done(8, c);
    wait_gnt(8, c);
    checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL wd_second: got %b need 1000", bus.gnt); end
    bus.req[3] = 1'b0;
    wait_done(8, c);
    checks++; if (c != 3 || bus.done !== 4'b1000 || bus.rdata !== m_read(16'h0020)) begin
      errors++; $display("FAIL wd_done: done=%b lat=%0d rdata=%h need 1000/3/%h", bus.done, c, bus.rdata, m_read(16'h0020));
    end
    wait_gnt(8, c);
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL wd_next: got %b need 0010", bus.gnt); end
    wait_done(8, c);
    bus.req = '0;
  endtask

  task automatic test_mid_reset();
    int c;
    logic [15:0] a;
    do_reset();
    set_req(0, 1'b1, 16'h0044, 32'h0);
    bus.req = 4'b0001;
    wait_gnt(8, c);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++; if (bus.gnt !== '0 || bus.done !== '0 || bus.mem_cs !== 0 || bus.rdata !== 0 || bus.err !== 0 ||
                  bus.mem_rw !== 0 || bus.mem_addr !== 0 || bus.mem_wdata !== 0) begin
      errors++; $display("FAIL mid_reset_outputs: gnt=%b done=%b cs=%b rdata=%h addr=%h need all 0",
                         bus.gnt, bus.done, bus.mem_cs, bus.rdata, bus.mem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.done !== '0) begin errors++; $display("FAIL mid_reset_nodone: got %b need 0", bus.done); end
    end
    a = {6'($urandom), 8'($urandom), 2'b00};
    set_req(0, 1'b1, a, 32'h0);
    reset = 1'b1;
    m_ptr = 0;
    m_mem.delete();
    wait_gnt(8, c);
    checks++; if (c != 1 || bus.gnt !== 4'b0001) begin errors++; $display("FAIL post_reset_gnt: got %b after %0d need 0001 after 1", bus.gnt, c); end
    wait_done(8, c);
    bus.req = '0;
    checks++; if (c != 3 || bus.rdata !== m_read(a)) begin errors++; $display("FAIL post_reset_rdata: got %h lat %0d need %h lat 3", bus.rdata, c, m_read(a)); end
  endtask

  task automatic test_spurious_ready();
    do_reset();
    poke = 1'b1;
    repeat (2) @(negedge clk);
    poke = 1'b0;
    checks++; if (bus.gnt !== '0 || bus.done !== '0 || bus.mem_cs !== 0) begin
      errors++; $display("FAIL spurious_ready: gnt=%b done=%b cs=%b need 0", bus.gnt, bus.done, bus.mem_cs);
    end
  endtask

  task automatic test_stall();
    int c;
    do_reset();
    set_req(2, 1'b1, 16'h0080, 32'h0);
    bus.req = 4'b0100;
    stall = 1'b1;
    wait_gnt(8, c);
    bus.req = '0;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    wait_done(40, c);
    checks++; if (c != TO || bus.done !== 4'b0100 || bus.err !== 1'b1) begin
      errors++; $display("FAIL timeout_done: lat=%0d done=%b err=%b need %0d/0100/1", c, bus.done, bus.err, TO);
    end
    checks++; if (bus.rdata !== 32'hDEAD_BEEF || bus.mem_cs !== 0) begin
      errors++; $display("FAIL timeout_rdata: rdata=%h cs=%b need deadbeef/0", bus.rdata, bus.mem_cs);
    end
    @(negedge clk);
    checks++; if (bus.err !== 0 || bus.done !== '0 || bus.mem_cs !== 0) begin
      errors++; $display("FAIL timeout_release: err=%b done=%b cs=%b need 0", bus.err, bus.done, bus.mem_cs);
    end
    stall = 1'b0;
`else
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checks++; if (bus.done !== '0 || bus.err !== 0 || bus.mem_cs !== 1) begin
        errors++; $display("FAIL stall_wait%0d: done=%b err=%b cs=%b need 0/0/1", i, bus.done, bus.err, bus.mem_cs);
      end
    end
    stall = 1'b0;
    wait_done(8, c);
    checks++; if (bus.done !== 4'b0100 || bus.err !== 0 || bus.rdata !== m_read(16'h0080)) begin
      errors++; $display("FAIL stall_done: done=%b err=%b rdata=%h need 0100/0/%h", bus.done, bus.err, bus.rdata, m_read(16'h0080));
    end
`endif
  endtask

  task automatic test_random();
    int c, w;
    logic [N-1:0] r;
    logic [15:0]  a;
    logic         rwv;
    logic [31:0]  d, exp_rd;
    do_reset();
    r = N'($urandom_range(1, (1 << N) - 1));
    randomize_inputs(r);
    for (int it = 0; it < 40; it++) begin
      w = rr_pick(r, m_ptr);
      rwv = bus.req_rw[w];
      a   = bus.req_addr[16*w +: 16];
      d   = bus.req_wdata[32*w +: 32];
      exp_rd = rwv ? m_read(a) : 32'h0;
      wait_gnt(8, c);
      checks++; if (c != 1 || bus.gnt !== N'(1) << w) begin
        errors++; $display("FAIL rnd_gnt%0d: got %b after %0d need %b after 1", it, bus.gnt, c, N'(1) << w);
      end
      checks++; if (bus.mem_cs !== 1 || bus.mem_rw !== rwv || bus.mem_addr !== a || bus.mem_wdata !== d) begin
        errors++; $display("FAIL rnd_cmd%0d: cs=%b rw=%b addr=%h wdata=%h need 1/%b/%h/%h", it, bus.mem_cs, bus.mem_rw,
                           bus.mem_addr, bus.mem_wdata, rwv, a, d);
      end
      randomize_inputs(N'($urandom));
      wait_done(8, c);
      checks++; if (c != 3 || bus.done !== N'(1) << w || bus.rdata !== exp_rd || bus.err !== 0) begin
        errors++; $display("FAIL rnd_done%0d: done=%b rdata=%h lat=%0d need %b/%h/3", it, bus.done, bus.rdata, c, N'(1) << w, exp_rd);
      end
      if (!rwv) m_mem[int'(a[9:2])] = d;
      m_ptr = (w + 1) % N;
      r = N'($urandom_range(1, (1 << N) - 1));
      randomize_inputs(r);
      @(negedge clk);
      checks++; if (bus.gnt !== '0 || bus.mem_cs !== 0 || bus.done !== '0 || bus.rdata !== 0) begin
        errors++; $display("FAIL rnd_release%0d: gnt=%b cs=%b done=%b rdata=%h need 0", it, bus.gnt, bus.mem_cs, bus.done, bus.rdata);
      end
    end
    bus.req = '0;
  endtask

  initial begin
    bus.req       = '0;
    bus.req_rw    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    test_reset();
    test_single_read();
    test_write_readback();
    test_contention();
    test_withdrawal();
    test_mid_reset();
    test_spurious_ready();
    test_stall();
    test_random();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Round-robin arbiter that shares the single-port 32-bit RAM slave among NUM_REQ requesters. It latches the winning requester's command and drives the slave's cs/rw/addr/data_in. It waits for the slave's ready pulse, returns read data with a one-cycle done pulse, then drops cs for one cycle so the slave's internal FSM returns to idle before the next grant.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYC, 15, cycles to wait for mem_ready before aborting (used only with the optional feature)

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  asynchronous, active-low reset (0 = in reset)
req  in  NUM_REQ  per-requester request level
req_rw  in  NUM_REQ  per-requester direction: 1 = read, 0 = write
req_addr  in  NUM_REQ*16  per-requester byte address; slice i = [16*i+15:16*i]
req_wdata  in  NUM_REQ*32  per-requester write data; slice i = [32*i+31:32*i]
gnt  out  NUM_REQ  one-hot: current owner of the slave
done  out  NUM_REQ  one-hot, one-cycle completion pulse
rdata  out  32  read data, valid while done is high
err  out  1  timeout abort flag, valid with done
mem_cs  out  1  slave chip select
mem_rw  out  1  slave direction
mem_addr  out  16  slave address
mem_wdata  out  32  slave write data
mem_ready  in  1  slave completion pulse
mem_rdata  in  32  slave read data

Behaviour:
- Reset (reset==0, asynchronous): state IDLE, round-robin pointer = 0 (req[0] highest priority). All outputs are 0: gnt, done, rdata, err, mem_cs, mem_rw, mem_addr, mem_wdata.
- Reset asserted mid-transaction aborts the transaction immediately. No done is issued. The slave is reset from the same reset domain.
- All outputs are registered. The FSM has three states: IDLE, ACCESS, RELEASE.
- IDLE:
  - If req is nonzero, select the first set bit starting at the pointer and searching upward with modulo NUM_REQ wrap.
  - At that edge: gnt <= onehot(winner); latch req_rw, req_addr and req_wdata of the winner into mem_rw, mem_addr and mem_wdata; mem_cs <= 1; state <= ACCESS.
  - If req is zero, stay in IDLE with all outputs held at 0.
- ACCESS:
  - mem_cs and the command stay stable. The latched command is used; requester inputs are ignored after the grant edge.
  - On an edge where mem_ready==1: rdata <= mem_rdata on a read, rdata <= 0 on a write; done <= gnt; mem_cs <= 0; state <= RELEASE.
- RELEASE (exactly one cycle):
  - done <= 0, gnt <= 0, mem_cs stays 0.
  - Pointer <= (winner+1) mod NUM_REQ.
  - state <= IDLE.
- Timing with the slave (edge T0 = grant edge):
  - Slave enters RUN at T1 and asserts ready after T2.
  - Arbiter samples ready at T3: done is high from T3 to T4, and mem_cs falls at T3.
  - Slave returns to idle at T4. The earliest next grant is T5.
  - Throughput: one transaction per 5 cycles.
- A requester dropping req after its grant does not cancel the transaction; done is still pulsed.
- A requester holding req continuously is re-eligible in the next IDLE, but only after the other requesting bits have been served (round-robin fairness).
- Simultaneous requests: exactly one grant. Never more than one bit set in gnt or in done.
- mem_ready while not in ACCESS is ignored.
- Without the optional feature, err is constant 0 and ACCESS waits indefinitely.

Optional Feature:
MEM_BUS_ARBITER_TIMEOUT_EN
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle.
  - If it reaches TIMEOUT_CYC without mem_ready: done <= gnt, err <= 1, rdata <= 32'hDEAD_BEEF, mem_cs <= 0, state <= RELEASE.
  - err clears in RELEASE.
- Not defined: no counter is instantiated and err is tied to 0.

Test Plan:
- Single read: preload RAM word 0x0010 = 0x1234_5678; req[2]=1, req_rw[2]=1, addr 0x0040 -> gnt=0b0100, mem_cs high 3 cycles, done[2] pulses 3 cycles after the grant edge with rdata=0x1234_5678, err=0.
- Write then read back: requester 1 writes 0xCAFE_F00D to 0x0100, then reads 0x0100 -> second done[1] carries rdata=0xCAFE_F00D. The second grant occurs no earlier than 5 cycles after the first.
- Contention: all 4 req held from reset -> grant order 0,1,2,3,0; gnt is always one-hot; each done coincides with the matching gnt bit.
- Request withdrawal: req[3] deasserted the cycle after the grant -> transaction completes and done[3] still pulses. The next IDLE grants only the remaining requesters.
- Reset mid-ACCESS: pull reset low at T2 -> all outputs 0 immediately and no done. After release, a fresh req[0] read completes normally.
- Timeout (feature on): replace the slave with a stub that never asserts ready, TIMEOUT_CYC=15 -> done and err pulse together 15 cycles after the grant, rdata=0xDEAD_BEEF, mem_cs low the following cycle.
